// File: rtl/mips_instr_encoder_if.sv
// rtl/mips_instr_encoder_if.sv - instruction-field input handshake and memory write bus
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        instr_id;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, instr_id, rs, rt, rd, shamt, imm, target, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, instr_id, rs, rt, rd, shamt, imm, target, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - packs decoded instruction fields into MIPS words streamed to memory
module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    mips_instr_encoder_if.slave  bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     word_count_o,
    output logic [CNT_W-1:0]     err_count_o
);
    // Instruction IDs: ADD..SLT = 0..6, SLL/SRL/SRA = 7..9, JR = 10,
    // SW LW ADDI ANDI ORI XORI SLTI BEQ BNE = 11..19, JMP = 20, JAL = 21.
    localparam logic [4:0] MAX_INSTR_ID = 5'd21;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    wc_q, wc_d, ec_q, ec_d;
    logic                err_q, err_d;

    logic                in_ready, accept, fire, start_go, legal;
    logic [31:0]         word;

    assign fire     = we_q & bus.mem_ready;
    assign accept   = bus.in_valid & in_ready;
    assign start_go = (state_q == S_IDLE) & start_i;

    always_comb begin
        legal = 1'b1;
        word  = 32'h0;
        unique case (bus.instr_id)
            5'd0:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
            5'd1:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
            5'd2:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
            5'd3:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
            5'd4:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100110};
            5'd5:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100111};
            5'd6:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b101010};
            5'd7:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000000};
            5'd8:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000010};
            5'd9:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000011};
            5'd10: word = {6'b000000, bus.rs, 15'd0, 6'b001000};
            5'd11: word = {6'b101011, bus.rs, bus.rt, bus.imm};
            5'd12: word = {6'b100011, bus.rs, bus.rt, bus.imm};
            5'd13: word = {6'b001000, bus.rs, bus.rt, bus.imm};
            5'd14: word = {6'b001100, bus.rs, bus.rt, bus.imm};
            5'd15: word = {6'b001101, bus.rs, bus.rt, bus.imm};
            5'd16: word = {6'b001110, bus.rs, bus.rt, bus.imm};
            5'd17: word = {6'b001010, bus.rs, bus.rt, bus.imm};
            5'd18: word = {6'b000100, bus.rs, bus.rt, bus.imm};
            5'd19: word = {6'b000101, bus.rs, bus.rt, bus.imm};
            5'd20: word = {6'b000010, bus.target};
            5'd21: word = {6'b000011, bus.target};
            default: legal = 1'b0;
        endcase
        if (bus.instr_id > MAX_INSTR_ID) legal = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (accept && bus.in_last) state_d = S_DRAIN;
            S_DRAIN: if (!we_q || bus.mem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) & (~we_q | bus.mem_ready);
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
    end

    // A drain and a new acceptance in the same cycle simply overwrite the register.
    always_comb begin
        we_d    = we_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        ec_d    = ec_q;
        err_d   = err_q;
        if (start_go) begin
            addr_d = ADDR_W'(BASE_ADDR);
            wc_d   = '0;
            ec_d   = '0;
            err_d  = 1'b0;
        end
        if (fire) begin
            we_d   = 1'b0;
            addr_d = addr_q + ADDR_W'(4);
            wc_d   = wc_q + CNT_W'(1);
        end
        if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                wdata_d = word;
            end else begin
                err_d = 1'b1;
                ec_d  = ec_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wc_q    <= '0;
            ec_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            ec_q    <= ec_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_addr  = addr_q;
    assign err_o         = err_q;
    assign word_count_o  = wc_q;
    assign err_count_o   = ec_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - directed and randomized checks of mips_instr_encoder against a field-table model
module tb_mips_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] wc, ec;

    always #5 clk = ~clk;

    mips_instr_encoder_if #(.ADDR_W(32)) bus ();

    mips_instr_encoder #(.BASE_ADDR(32'h0), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
        .busy_o(busy), .done_o(done), .err_o(err),
        .word_count_o(wc), .err_count_o(ec)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    int          exp_wc, exp_ec;
    bit          exp_err;
    bit          a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_word(int id, int rs, int rt, int rd, int sh, int imm, int tgt);
        int alu_f[7] = '{32, 34, 36, 37, 38, 39, 42};
        int sh_f[3]  = '{0, 2, 3};
        int i_op[9]  = '{43, 35, 8, 12, 13, 14, 10, 4, 5};
        longint w;
        if (id <= 6)       w = (rs << 21) + (rt << 16) + (rd << 11) + alu_f[id];
        else if (id <= 9)  w = (rt << 16) + (rd << 11) + (sh << 6) + sh_f[id-7];
        else if (id == 10) w = (rs << 21) + 8;
        else if (id <= 19) w = (longint'(i_op[id-11]) << 26) + (rs << 21) + (rt << 16) + imm;
        else               w = (longint'(id - 18) << 26) + tgt;
        return w[31:0];
    endfunction

    // One clock: score the write and acceptance that happen at the coming edge.
    task automatic step(output bit acc);
        bit fire, hold;
        logic [31:0] w0, a0, ew;
        #1;
        fire = bus.mem_we && bus.mem_ready;
        hold = bus.mem_we && !bus.mem_ready;
        acc  = bus.in_valid && bus.in_ready;
        w0 = bus.mem_wdata;
        a0 = bus.mem_addr;
        if (fire) begin
            chk("wr_addr", a0, exp_addr);
            ew = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("wr_data", w0, ew);
            exp_addr += 4;
            exp_wc++;
        end
        if (acc) begin
            if (bus.instr_id <= 21)
                exp_q.push_back(ref_word(bus.instr_id, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target));
            else begin
                exp_err = 1'b1;
                exp_ec++;
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("hold_we", {31'd0, bus.mem_we}, 32'd1);
            chk("hold_data", bus.mem_wdata, w0);
            chk("hold_addr", bus.mem_addr, a0);
        end
    endtask

    task automatic send_one(input int id, rs, rt, rd, sh, imm, tgt, input bit last, input bit rnd);
        bit got = 1'b0;
        bus.instr_id = 5'(id); bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd);
        bus.shamt = 5'(sh); bus.imm = 16'(imm); bus.target = 26'(tgt);
        bus.in_last = last;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
            step(got);
        end
        chk("accept", {31'd0, got}, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic send_rand(input bit illegal, input bit last);
        int id;
        id = illegal ? $urandom_range(22, 31) : $urandom_range(0, 21);
        send_one(id, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FF_FFFF), last, 1'b1);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 1'b0;
        bit acc;
        for (int k = 0; k < budget && !seen; k++) begin
            if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            seen = done;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            step(acc);
            chk("done_pulse", {31'd0, done}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic check_end();
        chk("word_count", {16'd0, wc}, 32'(exp_wc));
        chk("err_count", {16'd0, ec}, 32'(exp_ec));
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("end_addr", bus.mem_addr, exp_addr);
    endtask

    task automatic do_start();
        bit acc;
        start = 1'b1;
        step(acc);
        start = 1'b0;
        exp_addr = 32'h0; exp_wc = 0; exp_ec = 0; exp_err = 1'b0;
        exp_q.delete();
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.instr_id = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
        bus.shamt = 0; bus.imm = 0; bus.target = 0; bus.mem_ready = 1;
        exp_addr = 0; exp_wc = 0; exp_ec = 0; exp_err = 0;
        #1;
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_flags", {28'd0, done, err, busy, bus.in_ready}, 32'd0);
        chk("rst_counts", {wc, ec}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single ADD with in_last.
        do_start();
        send_one(0, 1, 2, 3, 0, 0, 0, 1'b1, 1'b0);
        chk("add_word", bus.mem_wdata, 32'h0022_1820);
        chk("add_addr", bus.mem_addr, 32'h0);
        wait_done(3, 1'b0);
        check_end();

        // Back-to-back stream at full throughput.
        do_start();
        send_one(13, 0, 8, 0, 0, 16'hFFFF, 0, 1'b0, 1'b0);
        chk("addi_word", bus.mem_wdata, 32'h2008_FFFF);
        chk("b2b_ready0", {31'd0, bus.in_ready}, 32'd1);
        send_one(12, 29, 4, 0, 0, 4, 0, 1'b0, 1'b0);
        chk("lw_word", bus.mem_wdata, 32'h8FA4_0004);
        chk("lw_addr", bus.mem_addr, 32'h4);
        chk("b2b_ready1", {31'd0, bus.in_ready}, 32'd1);
        send_one(21, 0, 0, 0, 0, 0, 26'h0000100, 1'b1, 1'b0);
        chk("jal_word", bus.mem_wdata, 32'h0C00_0100);
        chk("jal_addr", bus.mem_addr, 32'h8);
        wait_done(3, 1'b0);
        check_end();

        // Forced fields: SLL ignores rs, JR ignores rt/rd.
        do_start();
        send_one(7, 7, 3, 2, 4, 0, 0, 1'b0, 1'b0);
        chk("sll_word", bus.mem_wdata, 32'h0003_1100);
        send_one(10, 31, 5, 6, 9, 0, 0, 1'b1, 1'b0);
        chk("jr_word", bus.mem_wdata, 32'h03E0_0008);
        wait_done(3, 1'b0);
        check_end();

        // Back-pressure: five stalled cycles, then release.
        do_start();
        bus.mem_ready = 1'b0;
        send_one(1, 4, 5, 6, 0, 0, 0, 1'b0, 1'b0);
        bus.instr_id = 5'd15; bus.rs = 5'd1; bus.rt = 5'd2; bus.imm = 16'h1234; bus.in_last = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(a);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.mem_ready = 1'b1;
        step(a);
        chk("release_accept", {31'd0, a}, 32'd1);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("next_word", bus.mem_wdata, 32'h3422_1234);
        chk("next_addr", bus.mem_addr, 32'h4);
        wait_done(3, 1'b0);
        check_end();

        // Illegal ID between two legal instructions.
        do_start();
        send_one(0, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0);
        send_one(31, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0);
        send_one(1, 2, 2, 2, 0, 0, 0, 1'b1, 1'b0);
        wait_done(4, 1'b0);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_ec", {16'd0, ec}, 32'd1);
        chk("ill_wc", {16'd0, wc}, 32'd2);
        check_end();

        // Asynchronous reset while draining a stalled word.
        do_start();
        bus.mem_ready = 1'b0;
        send_one(4, 3, 3, 3, 0, 0, 0, 1'b1, 1'b0);
        step(a);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_flags", {29'd0, done, err, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        do_start();
        send_one(15, 1, 2, 0, 0, 16'h00FF, 0, 1'b1, 1'b0);
        chk("restart_addr", bus.mem_addr, 32'h0);
        wait_done(3, 1'b0);
        check_end();

        // Randomized programs with random back-pressure and gaps.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 12);
            do_start();
            for (int i = 0; i < n; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    bus.mem_ready = ($urandom_range(0, 3) != 0);
                    step(a);
                end
                send_rand($urandom_range(0, 5) == 0, i == n - 1);
            end
            wait_done(60, 1'b1);
            check_end();
        end

        // Every instruction illegal.
        do_start();
        for (int i = 0; i < 3; i++) send_rand(1'b1, i == 2);
        wait_done(5, 1'b1);
        chk("all_ill_wc", {16'd0, wc}, 32'd0);
        check_end();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder. Accepts decoded instruction fields (instruction ID plus register and immediate operands) and packs them into 32-bit MIPS machine words.
- Streams the words into instruction memory at consecutive word addresses. Used by the boot/program loader and by test benches to build programs.
- Sequential: input handshake, one-entry output register with memory back-pressure, address and word counters, run-control FSM, sticky illegal-instruction reporting.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after start.
- ADDR_W, 32, width of mem_addr.
- CNT_W, 16, width of word_count and err_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; in IDLE loads address with BASE_ADDR, clears counters and err, enters RUN.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_last  in  1  marks the final instruction of the program.
- instr_id  in  5  instruction index per the common instruction-ID header (ADD..JAL, max MAX_INSTR_ID).
- rs, rt, rd  in  5 each  register numbers.
- shamt  in  5  shift amount.
- imm  in  16  immediate or branch offset.
- target  in  26  jump target field.
- mem_we  out  1  write strobe (valid).
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  encoded word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of program.
- err  out  1  sticky: an illegal instr_id was seen since start.
- word_count  out  CNT_W  words written since start.
- err_count  out  CNT_W  illegal IDs dropped since start.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR.
  - done=0, err=0, word_count=0, err_count=0.
  - Reset mid-program discards the held word with no write.
- FSM:
  - IDLE: start → RUN. in_ready=0.
  - RUN: input accepted when in_valid & in_ready. Acceptance with in_last=1 → DRAIN.
  - DRAIN: in_ready=0; when the output register is empty (or empties this cycle) → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) & (!mem_we | mem_ready).
- Latency: an accepted instruction appears on mem_wdata/mem_we the next cycle.
- Output hold: the output holds stable until mem_we & mem_ready.
- Address and word count: on each mem_we & mem_ready, mem_addr += 4 and word_count += 1. Both wrap modulo their width with no flag.
- Encoding, R-type (opcode 000000):
  - Word is {opcode, rs, rt, rd, shamt, funct}.
  - funct: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010.
  - Shifts force rs=0: SLL 000000, SRL 000010, SRA 000011.
  - ALU ops (ADD..SLT) force shamt=0.
  - JR forces rt=rd=shamt=0, funct=001000.
- Encoding, I-type {opcode, rs, rt, imm}:
  - SW 101011, LW 100011, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, BEQ 000100, BNE 000101.
- Encoding, J-type {opcode, target}: JMP 000010, JAL 000011.
- Illegal instr_id (> MAX_INSTR_ID):
  - Still accepted, but no word is produced.
  - err set; err_count += 1; address unchanged.
  - If in_last accompanies an illegal ID, the FSM still goes to DRAIN.
- Simultaneous events: output drain and new acceptance in the same cycle replaces the output register with no bubble. Full throughput is 1 word/cycle while mem_ready=1.
- Whole-program drop: if every instruction was illegal, DONE is still reached with word_count=0.

Test Plan:
- Reset, start, ADD rs=1 rt=2 rd=3 with in_last, mem_ready=1 → next cycle mem_wdata=32'h0022_1820, mem_addr=0. done pulses within 3 cycles; word_count=1.
- Stream ADDI rs=0 rt=8 imm=16'hFFFF, LW rs=29 rt=4 imm=4, JAL target=26'h0000100, back-to-back → words 32'h2008_FFFF, 32'h8FA4_0004, 32'h0C00_0100 at addresses 0, 4, 8; in_ready stays 1.
- SLL rd=2 rt=3 shamt=4 with rs input=7 → word 32'h0003_1100 (rs forced 0). JR rs=31 with rt=5 rd=6 → 32'h03E0_0008.
- mem_ready held 0 for 5 cycles with in_valid=1 → in_ready=0, mem_wdata/mem_addr stable. Release → write completes and the next word follows on the following cycle.
- instr_id=31 between two valid instructions → err=1, err_count=1, the two valid words land at 0 and 4, word_count=2.
- Assert rst_n=0 while in DRAIN with mem_ready=0 → all outputs at reset values immediately; start afterwards restarts at BASE_ADDR.
